// File: rtl/mips_core_testbench.sv
// Single-cycle MIPS integer execute stage: decodes one instruction, computes the
// write-back value combinationally and registers it (one cycle of latency).
module mips_core_testbench #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       input_instruction,
    input  logic [DATA_W-1:0] rs_content,
    input  logic [DATA_W-1:0] rt_content,
    output logic [DATA_W-1:0] result
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [5:0]        opcode;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [4:0]        var_sh;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;

    assign opcode = input_instruction[31:26];
    assign shamt  = input_instruction[10:6];
    assign funct  = input_instruction[5:0];
    assign imm16  = input_instruction[15:0];
    assign sext   = {{(DATA_W-16){imm16[15]}}, imm16};
    assign zext   = {{(DATA_W-16){1'b0}}, imm16};
    assign var_sh = rs_content[4:0];

    // Register specifiers are resolved upstream; only their contents arrive here.
    logic unused_reg_fields;
    assign unused_reg_fields = ^input_instruction[25:16];

    always_comb begin
        result_d = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_SLL:  result_d = rt_content << shamt;
                    FN_SRL:  result_d = rt_content >> shamt;
                    FN_SRA:  result_d = $signed(rt_content) >>> shamt;
                    FN_SLLV: result_d = rt_content << var_sh;
                    FN_SRLV: result_d = rt_content >> var_sh;
                    FN_SRAV: result_d = $signed(rt_content) >>> var_sh;
                    FN_ADD, FN_ADDU: result_d = rs_content + rt_content;
                    FN_SUB, FN_SUBU: result_d = rs_content - rt_content;
                    FN_AND:  result_d = rs_content & rt_content;
                    FN_OR:   result_d = rs_content | rt_content;
                    FN_XOR:  result_d = rs_content ^ rt_content;
                    FN_NOR:  result_d = ~(rs_content | rt_content);
                    FN_SLT:  result_d = {{(DATA_W-1){1'b0}},
                                         $signed(rs_content) < $signed(rt_content)};
                    FN_SLTU: result_d = {{(DATA_W-1){1'b0}}, rs_content < rt_content};
                    default: result_d = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: result_d = rs_content + sext;
            OP_SLTI:  result_d = {{(DATA_W-1){1'b0}}, $signed(rs_content) < $signed(sext)};
            OP_SLTIU: result_d = {{(DATA_W-1){1'b0}}, rs_content < sext};
            OP_ANDI:  result_d = rs_content & zext;
            OP_ORI:   result_d = rs_content | zext;
            OP_XORI:  result_d = rs_content ^ zext;
            OP_LUI:   result_d = {imm16, {(DATA_W-16){1'b0}}};
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mips_core_testbench.sv
// Bench for the MIPS execute stage: directed vector table, reset/throughput
// sequences, and random instructions checked against an arithmetic model.
module tb_mips_core_testbench;

    logic        clk;
    logic        rst_n;
    logic [31:0] input_instruction;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mips_core_testbench #(.DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .input_instruction (input_instruction),
        .rs_content        (rs_content),
        .rt_content        (rt_content),
        .result            (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Reference model: each rule evaluated with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [31:0] ins,
                                              input logic [31:0] rs,
                                              input logic [31:0] rt);
        longint m    = 64'h1_0000_0000;
        longint urs  = longint'({32'h0, rs});
        longint urt  = longint'({32'h0, rt});
        longint srs  = longint'($signed(rs));
        longint srt  = longint'($signed(rt));
        longint uimm = longint'({48'h0, ins[15:0]});
        longint simm = longint'($signed(ins[15:0]));
        int     sh;
        longint p    = 1;
        longint r    = 0;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00 && (fn == 6'h04 || fn == 6'h06 || fn == 6'h07)) sh = int'(rs[4:0]);
        else sh = int'(ins[10:6]);
        for (int i = 0; i < sh; i++) p = p * 2;
        if (op == 6'h00) begin
            case (fn)
                6'h00, 6'h04: r = (urt * p) % m;
                6'h02, 6'h06: r = urt / p;
                6'h03, 6'h07: r = (srt >= 0) ? srt / p : -((-srt + p - 1) / p);
                6'h20, 6'h21: r = (urs + urt) % m;
                6'h22, 6'h23: r = (urs - urt + m) % m;
                6'h24: r = urs & urt;
                6'h25: r = urs | urt;
                6'h26: r = urs ^ urt;
                6'h27: r = (m - 1) - (urs | urt);
                6'h2A: r = (srs < srt) ? 1 : 0;
                6'h2B: r = (urs < urt) ? 1 : 0;
                default: r = 0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: r = (urs + simm + m) % m;
                6'h0A: r = (srs < simm) ? 1 : 0;
                6'h0B: r = (urs < (simm + m) % m) ? 1 : 0;
                6'h0C: r = urs & uimm;
                6'h0D: r = urs | uimm;
                6'h0E: r = urs ^ uimm;
                6'h0F: r = uimm * 65536;
                default: r = 0;
            endcase
        end
        r = r & (m - 1);
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: result %08h", name, act);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        input_instruction = ins;
        rs_content        = rs;
        rt_content        = rt;
    endtask

    logic [5:0]  valid_fn[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0]  valid_op[8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [31:0] edge_val[6]  = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                  32'h80000000, 32'h0000001F};

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(3) == 0) return edge_val[$urandom_range(5)];
        return $urandom;
    endfunction

    logic [31:0] tp_ins[4];
    logic [31:0] tp_rs[4];
    logic [31:0] tp_rt[4];
    logic [31:0] tp_exp[4];

    initial begin
        vecs.push_back('{32'h000B6043, 32'hDEADBEEF, 32'h80000004, 32'hC0000002, "sra neg"});
        vecs.push_back('{32'h000B6043, 32'hDEADBEEF, 32'h00000010, 32'h00000008, "sra pos"});
        vecs.push_back('{rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add wrap"});
        vecs.push_back('{rtype(6'h21, 5'd0), 32'hFFFFFFFF, 32'h00000002, 32'h00000001, "addu wrap"});
        vecs.push_back('{rtype(6'h20, 5'd7), 32'h00000001, 32'h00000002, 32'h00000003, "add shamt ignored"});
        vecs.push_back('{rtype(6'h22, 5'd0), 32'h00000005, 32'h00000007, 32'hFFFFFFFE, "sub"});
        vecs.push_back('{rtype(6'h2A, 5'd0), 32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt"});
        vecs.push_back('{rtype(6'h2B, 5'd0), 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu"});
        vecs.push_back('{rtype(6'h24, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and"});
        vecs.push_back('{rtype(6'h25, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or"});
        vecs.push_back('{rtype(6'h26, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor"});
        vecs.push_back('{rtype(6'h27, 5'd0), 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, "nor"});
        vecs.push_back('{rtype(6'h00, 5'd31), 32'h0, 32'h00000001, 32'h80000000, "sll 31"});
        vecs.push_back('{rtype(6'h02, 5'd0), 32'h0, 32'h12345678, 32'h12345678, "srl 0"});
        vecs.push_back('{rtype(6'h04, 5'd0), 32'h00000024, 32'h00000001, 32'h00000010, "sllv"});
        vecs.push_back('{rtype(6'h06, 5'd0), 32'h0000003F, 32'h80000000, 32'h00000001, "srlv 31"});
        vecs.push_back('{rtype(6'h07, 5'd0), 32'h0000003F, 32'h80000000, 32'hFFFFFFFF, "srav 31"});
        vecs.push_back('{itype(6'h08, 16'hFFFF), 32'h00000010, 32'h0, 32'h0000000F, "addi"});
        vecs.push_back('{itype(6'h0A, 16'hFFFF), 32'hFFFFFFFE, 32'h0, 32'h00000001, "slti"});
        vecs.push_back('{itype(6'h0B, 16'hFFFF), 32'h00000005, 32'h0, 32'h00000001, "sltiu"});
        vecs.push_back('{itype(6'h0C, 16'h8001), 32'hFFFFFFFF, 32'h0, 32'h00008001, "andi"});
        vecs.push_back('{itype(6'h0D, 16'h8001), 32'hF0000000, 32'h0, 32'hF0008001, "ori"});
        vecs.push_back('{itype(6'h0E, 16'hFFFF), 32'hFFFF0000, 32'h0, 32'hFFFFFFFF, "xori"});
        vecs.push_back('{itype(6'h0F, 16'h1234), 32'hFFFFFFFF, 32'h0, 32'h12340000, "lui"});
        vecs.push_back('{rtype(6'h3F, 5'd0), 32'h00000001, 32'h00000002, 32'h00000000, "undef funct"});
        vecs.push_back('{itype(6'h3F, 16'h1234), 32'h00000001, 32'h00000002, 32'h00000000, "undef opcode"});

        // Reset held with the sra instruction applied; result must stay cleared.
        rst_n = 1'b0;
        drive(32'h000B6043, 32'h0, 32'h80000004);
        @(posedge clk);
        #1 check("reset held", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset released, before edge", result, 32'h0);
        @(posedge clk);
        #1 check("first capture after reset", result, 32'hC0000002);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].rs, vecs[i].rt);
            @(posedge clk);
            #1 check(vecs[i].name, result, vecs[i].exp);
        end

        // Back-to-back instructions: each result one cycle later, and stable mid-cycle.
        tp_ins = '{rtype(6'h20, 5'd0), itype(6'h0F, 16'hABCD), 32'h000B6043, rtype(6'h2A, 5'd0)};
        tp_rs  = '{32'h00000003, 32'h0, 32'h0, 32'h00000005};
        tp_rt  = '{32'h00000004, 32'h0, 32'hFFFFFFF0, 32'h00000007};
        tp_exp = '{32'h00000007, 32'hABCD0000, 32'hFFFFFFF8, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            drive(tp_ins[i], tp_rs[i], tp_rt[i]);
            if (i > 0) #1 check($sformatf("throughput hold %0d", i), result, tp_exp[i-1]);
            @(posedge clk);
            #1 check($sformatf("throughput %0d", i), result, tp_exp[i]);
        end

        // Asynchronous clear in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1 check("async reset mid-cycle", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            logic [31:0] rs;
            logic [31:0] rt;
            logic [31:0] exp;
            ins = $urandom;
            case ($urandom_range(9))
                0, 1, 2, 3, 4: begin
                    ins[31:26] = 6'h00;
                    ins[5:0]   = valid_fn[$urandom_range(15)];
                end
                5, 6, 7, 8: ins[31:26] = valid_op[$urandom_range(7)];
                default: ;
            endcase
            rs  = rand_operand();
            rt  = rand_operand();
            exp = ref_model(ins, rs, rt);
            drive(ins, rs, rt);
            @(posedge clk);
            #1 check($sformatf("random %0d ins=%08h rs=%08h rt=%08h", n, ins, rs, rt), result, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
